// File: rtl/qdiv_pipe_hs.sv
// Signed Q(WIDTH-FRAC).FRAC restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define QDIV_ROUND_EN to compute one extra quotient bit and round half away from zero.
//
// state  | meaning
// IDLE   | in_ready high, waiting for operands
// DIVIDE | ITER restoring iterations, one per clock
// FIX    | sign correction, saturation, flag update
// HOLD   | out_valid high until out_ready
module qdiv_pipe_hs #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int NW = WIDTH + FRAC;
`ifdef QDIV_ROUND_EN
   localparam int ITER = NW + 1;
`else
   localparam int ITER = NW;
`endif
   localparam int CW = $clog2(ITER + 1);

   localparam logic [WIDTH-1:0] MAXV   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINV   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [NW:0]      MAXPOS = {{(FRAC+1){1'b0}}, MAXV};
   localparam logic [NW:0]      MAXNEG = {{(FRAC+1){1'b0}}, MINV};

   typedef enum logic [1:0] {IDLE, DIVIDE, FIX, HOLD} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ITER-1:0]  num_q, num_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sign_q, sign_d;
   logic             neg_q, neg_d;
   logic             zdiv_q, zdiv_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   trial;
   logic             ge;
   logic [NW:0]      qr;

   always_comb begin
      a_mag = dividend[WIDTH-1] ? -dividend : dividend;
      b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
      trial = {rem_q[WIDTH-1:0], num_q[ITER-1]};
      ge    = rem_q[WIDTH] | (trial >= {1'b0, dvs_q});
`ifdef QDIV_ROUND_EN
      // LSB of num_q is the extra half-LSB bit; adding it rounds the magnitude
      qr    = {1'b0, num_q[ITER-1:1]} + {{NW{1'b0}}, num_q[0]};
`else
      qr    = {1'b0, num_q};
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      num_d       = num_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      sign_d      = sign_q;
      neg_d       = neg_q;
      zdiv_d      = zdiv_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      quo_d       = quo_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               neg_d      = dividend[WIDTH-1];
               zdiv_d     = (divisor == '0);
               dvs_d      = b_mag;
               num_d      = ITER'(a_mag) << (ITER - WIDTH);
               rem_d      = '0;
               cnt_d      = CW'(ITER);
               in_ready_d = 1'b0;
               state_d    = DIVIDE;
            end
         end
         DIVIDE: begin
            // num_q shifts numerator bits out the top and quotient bits in at the bottom
            rem_d = ge ? (trial - {1'b0, dvs_q}) : trial;
            num_d = {num_q[ITER-2:0], ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            if (zdiv_q) begin
               quo_d = neg_q ? MINV : MAXV;
               dbz_d = 1'b1;
               ovf_d = 1'b0;
            end else begin
               dbz_d = 1'b0;
               if (!sign_q && (qr > MAXPOS)) begin
                  quo_d = MAXV;
                  ovf_d = 1'b1;
               end else if (sign_q && (qr > MAXNEG)) begin
                  quo_d = MINV;
                  ovf_d = 1'b1;
               end else begin
                  quo_d = sign_q ? -qr[WIDTH-1:0] : qr[WIDTH-1:0];
                  ovf_d = 1'b0;
               end
            end
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         num_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         sign_q      <= 1'b0;
         neg_q       <= 1'b0;
         zdiv_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quo_q       <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         num_q       <= num_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         sign_q      <= sign_d;
         neg_q       <= neg_d;
         zdiv_q      <= zdiv_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         quo_q       <= quo_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quo_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_qdiv_pipe_hs.sv
// Bench for qdiv_pipe_hs (WIDTH=32, FRAC=8): directed plan vectors, backpressure, reset abort,
// and random operands against an arithmetic reference model.
module tb_qdiv_pipe_hs;

   localparam int W = 32;
   localparam int F = 8;
`ifdef QDIV_ROUND_EN
   localparam int LAT = W + F + 2;
`else
   localparam int LAT = W + F + 1;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          in_ready, out_valid, div_by_zero, overflow;
   logic [W-1:0]  quotient;

   int checks = 0;
   int errors = 0;

   qdiv_pipe_hs #(.WIDTH(W), .FRAC(F)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns {div_by_zero, overflow, quotient} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, num, den, qm;
      logic neg;
      logic [W-1:0] q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return {1'b1, 1'b0, (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
      num = ((sa < 0) ? -sa : sa) * (longint'(1) << F);
      den = (sb < 0) ? -sb : sb;
`ifdef QDIV_ROUND_EN
      qm = (2 * num + den) / (2 * den);
`else
      qm = num / den;
`endif
      neg = a[W-1] ^ b[W-1];
      if (!neg && qm > 64'sh7FFF_FFFF) return {2'b01, 32'h7FFF_FFFF};
      if (neg && qm > 64'sh8000_0000) return {2'b01, 32'h8000_0000};
      q = neg ? 32'(-qm) : 32'(qm);
      return {2'b00, q};
   endfunction

   // Called #1 after a clock edge; returns #1 after the consume edge (or at out_valid if out_ready=0).
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit use_exp, input logic [W-1:0] eq, input logic edz, input logic eov);
      logic [W+1:0] exp;
      int n;
      exp = use_exp ? {edz, eov, eq} : model(a, b);
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      chk({tag, "_busy"}, 64'(in_ready), 64'd0);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(LAT));
      chk({tag, "_q"},   64'(quotient), 64'(exp[W-1:0]));
      chk({tag, "_dz"},  64'(div_by_zero), 64'(exp[W+1]));
      chk({tag, "_ov"},  64'(overflow), 64'(exp[W]));
      if (out_ready) begin
         @(posedge clk); #1;
         chk({tag, "_vld_fall"}, 64'(out_valid), 64'd0);
         chk({tag, "_rdy_rise"}, 64'(in_ready), 64'd1);
         chk({tag, "_dz_keep"}, 64'(div_by_zero), 64'(exp[W+1]));
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      bit seen;

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_quotient", 64'(quotient), 64'd0);
      chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);

      do_op("d12_3",  32'h0000_0C00, 32'h0000_0300, 1, 32'h0000_0400, 0, 0);
      do_op("dm75_2", 32'hFFFF_F880, 32'h0000_0200, 1, 32'hFFFF_FC40, 0, 0);
`ifdef QDIV_ROUND_EN
      do_op("d2_3",   32'h0000_0200, 32'h0000_0300, 1, 32'h0000_00AB, 0, 0);
      do_op("dm2_3",  32'hFFFF_FE00, 32'h0000_0300, 1, 32'hFFFF_FF55, 0, 0);
`else
      do_op("d2_3",   32'h0000_0200, 32'h0000_0300, 1, 32'h0000_00AA, 0, 0);
      do_op("dm2_3",  32'hFFFF_FE00, 32'h0000_0300, 1, 32'hFFFF_FF56, 0, 0);
`endif
      do_op("dz_p",   32'h0000_0500, 32'h0000_0000, 1, 32'h7FFF_FFFF, 1, 0);
      do_op("dz_n",   32'hFFFF_FB00, 32'h0000_0000, 1, 32'h8000_0000, 1, 0);
      do_op("dz_00",  32'h0000_0000, 32'h0000_0000, 1, 32'h7FFF_FFFF, 1, 0);
      do_op("ov_max", 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h7FFF_FFFF, 0, 1);
      do_op("ov_neg", 32'h8000_0000, 32'hFFFF_FF00, 1, 32'h7FFF_FFFF, 0, 1);
      do_op("min_1",  32'h8000_0000, 32'h0000_0100, 1, 32'h8000_0000, 0, 0);

      // backpressure: result held, in_valid ignored
      out_ready = 1'b0;
      do_op("bp", 32'h0000_0C00, 32'h0000_0300, 1, 32'h0000_0400, 0, 0);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom);
         dividend = $urandom;
         divisor  = $urandom;
         @(posedge clk); #1;
         chk("bp_q", 64'(quotient), 64'h400);
         chk("bp_vld", 64'(out_valid), 64'd1);
         chk("bp_rdy", 64'(in_ready), 64'd0);
         chk("bp_flags", 64'({div_by_zero, overflow}), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_vld_fall", 64'(out_valid), 64'd0);
      chk("bp_rdy_rise", 64'(in_ready), 64'd1);
      do_op("bp_b2b", 32'h0000_0C00, 32'h0000_0300, 1, 32'h0000_0400, 0, 0);

      // reset during iteration 20 aborts the operation
      dividend = 32'h0000_0C00;
      divisor  = 32'h0000_0300;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("ab_in_ready", 64'(in_ready), 64'd1);
      chk("ab_out_valid", 64'(out_valid), 64'd0);
      chk("ab_quotient", 64'(quotient), 64'd0);
      chk("ab_flags", 64'({div_by_zero, overflow}), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("ab_no_result", 64'(seen), 64'd0);
      do_op("ab_12_3", 32'h0000_0C00, 32'h0000_0300, 1, 32'h0000_0400, 0, 0);

      // random operands against the model
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 3 == 0) rb = 32'($urandom_range(0, 4095)) - 32'd2048;
         if (i % 5 == 1) ra = 32'($urandom_range(0, 65535)) - 32'd32768;
         do_op("rnd", ra, rb, 0, '0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
